axim_wr_master: RTL

AXI4-Lite write master that turns a simple valid/ready command stream (address + data) into single-beat AXI write transactions. Sits directly upstream of the map-inflation control-register slave: the host-side or sequencer logic pushes register writes here, and this block drives the slave's AW/W/B channels. A small command FIFO decouples producers from bus latency, and counters report completed writes and error responses.

---
 rtl/axim_wr_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axim_wr_master.sv
// ============================================================================
// Module   : axim_wr_master
// Purpose  : Command-FIFO-fed AXI4-Lite single-beat write master with
//            completion/error counters and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axim_wr_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic                     busy,
  output logic [15:0]              wr_count,
  output logic [15:0]              err_count,
  output logic                     err_flag,
  input  logic                     err_clr
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_DATA = 2'd1,
    S_RESP      = 2'd2
  } state_t;

  logic [ENTRY_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic [15:0]              wr_count_q, wr_count_d;
  logic [15:0]              err_count_q, err_count_d;
  logic                     err_flag_q, err_flag_d;

  logic                     push;
  logic                     pop;
  logic [ENTRY_W-1:0]       head;

  assign cmd_ready = (count_q != (PTR_W+1)'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;

    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);

    // Clear first so an error response in the same cycle overrides it.
    if (err_clr) err_flag_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          awaddr_d  = head[ENTRY_W-1:DATA_WIDTH];
          wdata_d   = head[DATA_WIDTH-1:0];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_ADDR_DATA;
        end
      end
      S_ADDR_DATA: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          bready_d   = 1'b0;
          wr_count_d = wr_count_q + 16'd1;
          if (m_axi_bresp[1]) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            err_flag_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      wr_count_q  <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign wr_count      = wr_count_q;
  assign err_count     = err_count_q;
  assign err_flag      = err_flag_q;

endmodule

`default_nettype wire
